// File: rtl/fwd_hazard_if.sv
// Operand-forwarding bus between the ID stage and the forwarding/hazard unit.
// The master drives the issue and stage data, and the slave returns the resolved operands and the stall.
interface fwd_hazard_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned NSRC   = 2,
  parameter int unsigned DEPTH  = 3
);
  localparam int unsigned SELW = $clog2(DEPTH + 1);

  logic                     stall_ext;
  logic                     flush_all;
  logic                     issue_valid;
  logic                     issue_we;
  logic                     issue_is_load;
  logic [REG_AW-1:0]        issue_rd;
  logic [NSRC*REG_AW-1:0]   issue_rs;
  logic [NSRC*XLEN-1:0]     rf_data;
  logic [XLEN-1:0]          ex_result;
  logic [XLEN-1:0]          mem_load_data;
  logic [NSRC*XLEN-1:0]     opnd_data;
  logic [NSRC*SELW-1:0]     fwd_sel;
  logic                     hazard_stall;
  logic [15:0]              stall_cnt;

  modport master (
    output stall_ext, flush_all, issue_valid, issue_we, issue_is_load, issue_rd,
           issue_rs, rf_data, ex_result, mem_load_data,
    input  opnd_data, fwd_sel, hazard_stall, stall_cnt
  );

  modport slave (
    input  stall_ext, flush_all, issue_valid, issue_we, issue_is_load, issue_rd,
           issue_rs, rf_data, ex_result, mem_load_data,
    output opnd_data, fwd_sel, hazard_stall, stall_cnt
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard unit. A DEPTH-slot queue tracks in-flight register writes, with slot 0 as EX.
// Each source operand takes its value from the youngest matching producer, and a load-use dependency raises a stall.
module fwd_hazard_unit #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned NSRC       = 2,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LOAD_STAGE = 1
) (
  input  logic         clk,
  input  logic         rst,
  fwd_hazard_if.slave  bus
);
  localparam int unsigned SELW = $clog2(DEPTH + 1);
  localparam int unsigned CNTW = 16;

  typedef struct packed {
    logic              valid;
    logic              match_en;
    logic [REG_AW-1:0] rd;
    logic              is_load;
    logic              ready;
    logic [XLEN-1:0]   data;
  } slot_t;

  slot_t            slots_q [DEPTH];
  slot_t            slots_d [DEPTH];
  slot_t            cap_c   [DEPTH];
  slot_t            tag_c;
  logic [NSRC-1:0]  found_c;
  logic [NSRC-1:0]  unavail_c;
  logic             hazard_c;
  logic             push_c;
  logic [CNTW-1:0]  stall_cnt_q;
  logic [CNTW-1:0]  stall_cnt_d;

  // Operand resolution: the first hit from slot 0 upward is the youngest producer
  always_comb begin
    bus.opnd_data = bus.rf_data;
    bus.fwd_sel   = '0;
    found_c       = '0;
    unavail_c     = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        if (!found_c[i] && slots_q[k].valid && slots_q[k].match_en &&
            (slots_q[k].rd == bus.issue_rs[i*REG_AW +: REG_AW])) begin
          found_c[i]                     = 1'b1;
          bus.fwd_sel[i*SELW +: SELW]    = SELW'(k + 1);
          if (slots_q[k].ready) begin
            bus.opnd_data[i*XLEN +: XLEN] = slots_q[k].data;
          end else if ((k == 0) && !slots_q[k].is_load) begin
            bus.opnd_data[i*XLEN +: XLEN] = bus.ex_result;
          end else if ((k == LOAD_STAGE) && slots_q[k].is_load) begin
            bus.opnd_data[i*XLEN +: XLEN] = bus.mem_load_data;
          end else begin
            unavail_c[i] = 1'b1;
          end
        end
      end
    end
  end

  assign hazard_c         = bus.issue_valid && !rst && (|unavail_c);
  assign push_c           = bus.issue_valid && !hazard_c && !bus.flush_all;
  assign bus.hazard_stall = hazard_c;
  assign bus.stall_cnt    = stall_cnt_q;

  // Capture stage results in place, then shift or hold the queue
  always_comb begin
    tag_c          = '0;
    tag_c.valid    = 1'b1;
    tag_c.match_en = bus.issue_we && (bus.issue_rd != '0);
    tag_c.rd       = bus.issue_rd;
    tag_c.is_load  = bus.issue_is_load;

    for (int unsigned k = 0; k < DEPTH; k++) begin
      cap_c[k] = slots_q[k];
      if (slots_q[k].valid && !slots_q[k].ready) begin
        if ((k == 0) && !slots_q[k].is_load) begin
          cap_c[k].data  = bus.ex_result;
          cap_c[k].ready = 1'b1;
        end else if ((k == LOAD_STAGE) && slots_q[k].is_load) begin
          cap_c[k].data  = bus.mem_load_data;
          cap_c[k].ready = 1'b1;
        end
      end
    end

    for (int unsigned k = 0; k < DEPTH; k++) begin
      slots_d[k] = cap_c[k];
    end
    if (!bus.stall_ext) begin
      for (int unsigned k = 1; k < DEPTH; k++) begin
        slots_d[k] = cap_c[k-1];
      end
      slots_d[0] = push_c ? tag_c : '0;
    end
    if (bus.flush_all) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        slots_d[k] = '0;
      end
    end
  end

  // Saturating count of cycles in which the hazard stall actually holds the front end
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hazard_c && !bus.stall_ext && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        slots_q[k] <= '0;
      end
      stall_cnt_q <= '0;
    end else begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        slots_q[k] <= slots_d[k];
      end
      stall_cnt_q <= stall_cnt_d;
    end
  end
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit. The expected values are computed by hand from the default parameters.
// The default parameters are EX/MEM/WB slots with load data arriving in slot 1.
module tb_fwd_hazard_unit;
  localparam logic [31:0] RF0 = 32'hF0F0_0000;
  localparam logic [31:0] RF1 = 32'hF1F1_0000;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  logic [15:0] exp_cnt;

  fwd_hazard_if #(.XLEN(32), .REG_AW(5), .NSRC(2), .DEPTH(3)) bus ();

  fwd_hazard_unit #(.XLEN(32), .REG_AW(5), .NSRC(2), .DEPTH(3), .LOAD_STAGE(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_issue(input logic v, input logic we, input logic ld,
                           input logic [4:0] rd, input logic [4:0] rs0, input logic [4:0] rs1);
    bus.issue_valid   = v;
    bus.issue_we      = we;
    bus.issue_is_load = ld;
    bus.issue_rd      = rd;
    bus.issue_rs      = {rs1, rs0};
  endtask

  task automatic idle();
    set_issue(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic clear_queue();
    idle();
    bus.flush_all = 1'b1;
    tick();
    bus.flush_all = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_issue(1'b1, 1'b0, 1'b0, 5'd0, 5'd7, 5'd5);
    #1;
    checks++; if (bus.hazard_stall !== 1'b0) begin errors++; $display("FAIL rst_hazard: got %b want 0", bus.hazard_stall); end
    tick();
    tick();
    checks++; if (bus.stall_cnt !== 16'd0) begin errors++; $display("FAIL rst_cnt: got %0d want 0", bus.stall_cnt); end
    rst = 1'b0;
    set_issue(1'b1, 1'b0, 1'b0, 5'd0, 5'd5, 5'd7);
    #1;
    checks++; if (bus.opnd_data !== {RF1, RF0}) begin errors++; $display("FAIL rst_opnd: got %h want %h", bus.opnd_data, {RF1, RF0}); end
    checks++; if (bus.fwd_sel !== 4'b0000) begin errors++; $display("FAIL rst_sel: got %b want 0000", bus.fwd_sel); end
    checks++; if (bus.hazard_stall !== 1'b0) begin errors++; $display("FAIL rst_nostall: got %b want 0", bus.hazard_stall); end
    tick();
    idle();
  endtask

  task automatic test_alu_dep();
    clear_queue();
    set_issue(1'b1, 1'b1, 1'b0, 5'd5, 5'd0, 5'd0);
    tick();
    set_issue(1'b1, 1'b0, 1'b0, 5'd0, 5'd5, 5'd6);
    bus.ex_result = 32'h1234;
    #1;
    checks++; if (bus.opnd_data[31:0] !== 32'h1234) begin errors++; $display("FAIL alu_opnd0: got %h want 00001234", bus.opnd_data[31:0]); end
    checks++; if (bus.fwd_sel[1:0] !== 2'd1) begin errors++; $display("FAIL alu_sel0: got %0d want 1", bus.fwd_sel[1:0]); end
    checks++; if (bus.opnd_data[63:32] !== RF1) begin errors++; $display("FAIL alu_opnd1: got %h want %h", bus.opnd_data[63:32], RF1); end
    checks++; if (bus.fwd_sel[3:2] !== 2'd0) begin errors++; $display("FAIL alu_sel1: got %0d want 0", bus.fwd_sel[3:2]); end
    checks++; if (bus.hazard_stall !== 1'b0) begin errors++; $display("FAIL alu_stall: got %b want 0", bus.hazard_stall); end
    tick();
    bus.ex_result = 32'h9999;
    set_issue(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd5);
    #1;
    checks++; if (bus.opnd_data[63:32] !== 32'h1234) begin errors++; $display("FAIL alu_mem_opnd1: got %h want 00001234", bus.opnd_data[63:32]); end
    checks++; if (bus.fwd_sel[3:2] !== 2'd2) begin errors++; $display("FAIL alu_mem_sel1: got %0d want 2", bus.fwd_sel[3:2]); end
    tick();
    idle();
  endtask

  task automatic test_load_use();
    clear_queue();
    set_issue(1'b1, 1'b1, 1'b1, 5'd7, 5'd0, 5'd0);
    tick();
    set_issue(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd7);
    bus.mem_load_data = 32'h0;
    #1;
    checks++; if (bus.hazard_stall !== 1'b1) begin errors++; $display("FAIL lu_stall: got %b want 1", bus.hazard_stall); end
    tick();
    exp_cnt = exp_cnt + 16'd1;
    checks++; if (bus.stall_cnt !== exp_cnt) begin errors++; $display("FAIL lu_cnt: got %0d want %0d", bus.stall_cnt, exp_cnt); end
    bus.mem_load_data = 32'hCAFE;
    #1;
    checks++; if (bus.hazard_stall !== 1'b0) begin errors++; $display("FAIL lu_release: got %b want 0", bus.hazard_stall); end
    checks++; if (bus.opnd_data[63:32] !== 32'hCAFE) begin errors++; $display("FAIL lu_opnd1: got %h want 0000cafe", bus.opnd_data[63:32]); end
    checks++; if (bus.fwd_sel[3:2] !== 2'd2) begin errors++; $display("FAIL lu_sel1: got %0d want 2", bus.fwd_sel[3:2]); end
    checks++; if (bus.opnd_data[31:0] !== RF0) begin errors++; $display("FAIL lu_opnd0_x0: got %h want %h", bus.opnd_data[31:0], RF0); end
    tick();
    bus.mem_load_data = 32'hBEEF;
    set_issue(1'b1, 1'b0, 1'b0, 5'd0, 5'd7, 5'd0);
    #1;
    checks++; if (bus.opnd_data[31:0] !== 32'hCAFE) begin errors++; $display("FAIL lu_wb_opnd0: got %h want 0000cafe", bus.opnd_data[31:0]); end
    checks++; if (bus.fwd_sel[1:0] !== 2'd3) begin errors++; $display("FAIL lu_wb_sel0: got %0d want 3", bus.fwd_sel[1:0]); end
    tick();
    idle();
  endtask

  task automatic test_priority();
    clear_queue();
    set_issue(1'b1, 1'b1, 1'b0, 5'd3, 5'd0, 5'd0);
    bus.ex_result = 32'h11;
    tick();
    idle();
    tick();
    set_issue(1'b1, 1'b1, 1'b0, 5'd3, 5'd0, 5'd0);
    tick();
    bus.ex_result = 32'h22;
    set_issue(1'b1, 1'b0, 1'b0, 5'd0, 5'd3, 5'd3);
    #1;
    checks++; if (bus.opnd_data !== {32'h22, 32'h22}) begin errors++; $display("FAIL prio_opnd: got %h want 0000002200000022", bus.opnd_data); end
    checks++; if (bus.fwd_sel !== 4'b0101) begin errors++; $display("FAIL prio_sel: got %b want 0101", bus.fwd_sel); end
    checks++; if (bus.hazard_stall !== 1'b0) begin errors++; $display("FAIL prio_stall: got %b want 0", bus.hazard_stall); end
    tick();
    idle();
  endtask

  task automatic test_x0_nowe();
    clear_queue();
    set_issue(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    tick();
    set_issue(1'b1, 1'b0, 1'b0, 5'd9, 5'd0, 5'd0);
    tick();
    set_issue(1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0);
    tick();
    bus.ex_result = 32'h5555;
    set_issue(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd9);
    #1;
    checks++; if (bus.opnd_data !== {RF1, RF0}) begin errors++; $display("FAIL x0_opnd: got %h want %h", bus.opnd_data, {RF1, RF0}); end
    checks++; if (bus.fwd_sel !== 4'b0000) begin errors++; $display("FAIL x0_sel: got %b want 0000", bus.fwd_sel); end
    checks++; if (bus.hazard_stall !== 1'b0) begin errors++; $display("FAIL x0_stall: got %b want 0", bus.hazard_stall); end
    tick();
    idle();
  endtask

  task automatic test_stall_ext();
    clear_queue();
    set_issue(1'b1, 1'b1, 1'b1, 5'd7, 5'd0, 5'd0);
    tick();
    bus.stall_ext = 1'b1;
    bus.mem_load_data = 32'h0;
    set_issue(1'b1, 1'b0, 1'b0, 5'd0, 5'd7, 5'd0);
    for (int n = 0; n < 3; n++) begin
      #1;
      checks++; if (bus.hazard_stall !== 1'b1) begin errors++; $display("FAIL hold_stall%0d: got %b want 1", n, bus.hazard_stall); end
      tick();
      checks++; if (bus.stall_cnt !== exp_cnt) begin errors++; $display("FAIL hold_cnt%0d: got %0d want %0d", n, bus.stall_cnt, exp_cnt); end
    end
    bus.stall_ext = 1'b0;
    #1;
    checks++; if (bus.hazard_stall !== 1'b1) begin errors++; $display("FAIL hold_rel_stall: got %b want 1", bus.hazard_stall); end
    tick();
    exp_cnt = exp_cnt + 16'd1;
    checks++; if (bus.stall_cnt !== exp_cnt) begin errors++; $display("FAIL hold_rel_cnt: got %0d want %0d", bus.stall_cnt, exp_cnt); end
    bus.mem_load_data = 32'hD00D;
    #1;
    checks++; if (bus.hazard_stall !== 1'b0) begin errors++; $display("FAIL hold_done_stall: got %b want 0", bus.hazard_stall); end
    checks++; if (bus.opnd_data[31:0] !== 32'hD00D) begin errors++; $display("FAIL hold_opnd0: got %h want 0000d00d", bus.opnd_data[31:0]); end
    checks++; if (bus.fwd_sel[1:0] !== 2'd2) begin errors++; $display("FAIL hold_sel0: got %0d want 2", bus.fwd_sel[1:0]); end
    tick();
    idle();
  endtask

  task automatic test_flush_rst();
    clear_queue();
    set_issue(1'b1, 1'b1, 1'b1, 5'd7, 5'd0, 5'd0);
    tick();
    set_issue(1'b1, 1'b0, 1'b0, 5'd0, 5'd7, 5'd0);
    bus.flush_all = 1'b1;
    #1;
    checks++; if (bus.hazard_stall !== 1'b1) begin errors++; $display("FAIL fl_stall: got %b want 1", bus.hazard_stall); end
    tick();
    bus.flush_all = 1'b0;
    exp_cnt = exp_cnt + 16'd1;
    checks++; if (bus.stall_cnt !== exp_cnt) begin errors++; $display("FAIL fl_cnt: got %0d want %0d", bus.stall_cnt, exp_cnt); end
    #1;
    checks++; if (bus.hazard_stall !== 1'b0) begin errors++; $display("FAIL fl_nostall: got %b want 0", bus.hazard_stall); end
    checks++; if (bus.fwd_sel[1:0] !== 2'd0) begin errors++; $display("FAIL fl_sel0: got %0d want 0", bus.fwd_sel[1:0]); end
    checks++; if (bus.opnd_data[31:0] !== RF0) begin errors++; $display("FAIL fl_opnd0: got %h want %h", bus.opnd_data[31:0], RF0); end
    tick();
    set_issue(1'b1, 1'b1, 1'b1, 5'd7, 5'd0, 5'd0);
    tick();
    rst = 1'b1;
    set_issue(1'b1, 1'b0, 1'b0, 5'd0, 5'd7, 5'd0);
    #1;
    checks++; if (bus.hazard_stall !== 1'b0) begin errors++; $display("FAIL rs_stall_in_rst: got %b want 0", bus.hazard_stall); end
    tick();
    rst = 1'b0;
    exp_cnt = 16'd0;
    checks++; if (bus.stall_cnt !== exp_cnt) begin errors++; $display("FAIL rs_cnt: got %0d want 0", bus.stall_cnt); end
    #1;
    checks++; if (bus.hazard_stall !== 1'b0) begin errors++; $display("FAIL rs_nostall: got %b want 0", bus.hazard_stall); end
    checks++; if (bus.fwd_sel[1:0] !== 2'd0) begin errors++; $display("FAIL rs_sel0: got %0d want 0", bus.fwd_sel[1:0]); end
    checks++; if (bus.opnd_data[31:0] !== RF0) begin errors++; $display("FAIL rs_opnd0: got %h want %h", bus.opnd_data[31:0], RF0); end
    tick();
    idle();
  endtask

  task automatic test_back_to_back();
    clear_queue();
    set_issue(1'b1, 1'b1, 1'b0, 5'd5, 5'd0, 5'd0);
    tick();
    idle();
    bus.ex_result = 32'h77;
    tick();
    bus.ex_result = 32'h0;
    tick();
    set_issue(1'b1, 1'b0, 1'b0, 5'd0, 5'd5, 5'd0);
    #1;
    checks++; if (bus.opnd_data[31:0] !== 32'h77) begin errors++; $display("FAIL b2b_opnd0: got %h want 00000077", bus.opnd_data[31:0]); end
    checks++; if (bus.fwd_sel[1:0] !== 2'd3) begin errors++; $display("FAIL b2b_sel0: got %0d want 3", bus.fwd_sel[1:0]); end
    checks++; if (bus.hazard_stall !== 1'b0) begin errors++; $display("FAIL b2b_stall: got %b want 0", bus.hazard_stall); end
    tick();
    #1;
    checks++; if (bus.fwd_sel[1:0] !== 2'd0) begin errors++; $display("FAIL b2b_retired_sel0: got %0d want 0", bus.fwd_sel[1:0]); end
    tick();
    idle();
  endtask

  initial begin
    errors            = 0;
    checks            = 0;
    exp_cnt           = 16'd0;
    rst               = 1'b1;
    bus.stall_ext     = 1'b0;
    bus.flush_all     = 1'b0;
    bus.rf_data       = {RF1, RF0};
    bus.ex_result     = 32'h0;
    bus.mem_load_data = 32'h0;
    idle();
    test_reset();
    test_alu_dep();
    test_load_use();
    test_priority();
    test_x0_nowe();
    test_stall_ext();
    test_flush_rst();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
